if_id_fetch_stage: RTL and testbench
====================================

IF_ID_FETCH_STAGE -- requirements
Module: if_id_fetch_stage

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high; ports named clock and reset.
REQ-002 SHALL expose: clock  in  1  pipeline clock; all state updates on the falling edge, matching the downstream ID/EX register.
REQ-003 SHALL expose: reset  in  1  synchronous active-high reset, sampled on the falling edge.
REQ-004 SHALL expose: hit  in  1  pipeline advance enable; 0 = stall, hold IF/ID outputs.
REQ-005 SHALL expose: branchTaken  in  1  redirect request from the branch resolution stage.
REQ-006 SHALL expose: branchTarget  in  32  redirect PC; bits [1:0] ignored and forced to 00.
REQ-007 SHALL expose: imemRequest  out  1  instruction memory read request.
REQ-008 SHALL expose: imemAddress  out  32  word-aligned fetch address, stable while imemRequest is high.
REQ-009 SHALL expose: imemReady  in  1  memory completion; imemData valid in the same cycle.
REQ-010 SHALL expose: imemData  in  32  fetched instruction word.
REQ-011 SHALL expose: instructionOut  out  32  IF/ID instruction to decode.
REQ-012 SHALL expose: nextPCOut  out  32  fetch address + 4 for the instruction in instructionOut.
REQ-013 SHALL expose: validOut  out  1  instructionOut holds a real instruction (0 = bubble).

Function
REQ-014 SHALL implement FSM states FETCH, HOLD, DRAIN.
REQ-015 FETCH: imemRequest=1, imemAddress=PC; a transfer completes on an edge where imemRequest and imemReady are both 1.
REQ-016 FETCH with completion and hit=1: load instructionOut=imemData, nextPCOut=PC+4, validOut=1; PC<=PC+4; stay in FETCH (1 instruction/cycle with zero-wait memory).
REQ-017 FETCH with completion and hit=0: capture imemData in a 1-entry buffer; IF/ID outputs hold; go to HOLD.
REQ-018 FETCH without completion: IF/ID outputs hold if hit=0; if hit=1, load a bubble (validOut=0, instructionOut=0).
REQ-019 HOLD: imemRequest=0; when hit=1, move the buffer to IF/ID as in REQ-016, PC<=PC+4, go to FETCH.
REQ-020 branchTaken SHALL take priority over hit: PC<=branchTarget&~3, IF/ID loaded with a bubble, buffer invalidated.
REQ-021 branchTaken in FETCH without completion SHALL go to DRAIN, holding imemRequest=1 and the old imemAddress until imemReady; returned data discarded; then FETCH at the new PC.
REQ-022 branchTaken in FETCH with completion, in HOLD, or in DRAIN SHALL discard the returned or buffered word and go to FETCH (DRAIN: stay until its outstanding completion).
REQ-023 imemReady while imemRequest=0 SHALL be ignored.
REQ-024 PC arithmetic SHALL be 32-bit modulo; 0xFFFFFFFC+4 wraps to 0x00000000.
REQ-025 imemAddress SHALL change only on edges where no transfer is outstanding or one completes.

Reset
REQ-026 reset SHALL force: PC=0, state=FETCH, buffer invalid, instructionOut=0, nextPCOut=0, validOut=0; it overrides branchTaken and hit.
REQ-027 After reset, imemRequest=1 with imemAddress=0 from the first post-reset cycle.
REQ-028 Reset during a transfer SHALL abandon it; the memory model treats a request drop as a cancel.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding, RESET_PC=32'h0, PC_INCREMENT=4, and the NOP/bubble word 32'h0.
REQ-030 One sub-module, pc_register (PC hold/increment/redirect), is natural; the FSM, buffer and IF/ID register stay in the top.

Verification
REQ-031 Zero-wait memory, hit=1, imem returns 0x20080005 at addr 0 -> next edge instructionOut=0x20080005, nextPCOut=4, validOut=1; 4 consecutive instructions on 4 edges.
REQ-032 2-cycle memory latency, hit=1 -> validOut=0 bubble on the intermediate edge, then the instruction with correct nextPCOut.
REQ-033 Completion at PC=0x10 while hit=0 for 3 cycles -> outputs frozen, imemRequest=0; hit=1 -> instructionOut=word@0x10, nextPCOut=0x14.
REQ-034 branchTaken with target 0x43 while a fetch of 0x08 is outstanding -> DRAIN holds addr 0x08; its data discarded; next request addr 0x40; validOut=0 until 0x40 returns.
REQ-035 PC=0xFFFFFFFC fetched -> nextPCOut=0x00000000, next imemAddress=0x00000000.
REQ-036 reset asserted together with branchTaken mid-transfer -> all outputs 0, next request addr 0.

Source files
------------

// File: rtl/if_id_fetch_stage_pkg.sv
// ---------------------------------------------------------------------------
// if_id_fetch_stage_pkg
// Shared definitions for the instruction fetch stage and its IF/ID register:
//   fetchState_t  - fetch FSM state encoding (FETCH, HOLD, DRAIN)
//   RESET_PC      - program counter value after reset
//   PC_INCREMENT  - byte distance between consecutive instructions
//   NOP_WORD      - instruction word used for pipeline bubbles
//   wordAlign()   - clears the byte-offset bits of an address
// ---------------------------------------------------------------------------
package if_id_fetch_stage_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetchState_t;

  localparam logic [31:0] RESET_PC     = 32'h0000_0000;
  localparam logic [31:0] PC_INCREMENT = 32'd4;
  localparam logic [31:0] NOP_WORD     = 32'h0000_0000;

  // Instructions are word aligned, so the two low address bits never matter.
  function automatic logic [31:0] wordAlign(input logic [31:0] address);
    return {address[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_fetch_stage_pc_register.sv
// ---------------------------------------------------------------------------
// pc_register
// Program counter for the fetch stage. Holds, increments by one instruction,
// or redirects to a word-aligned branch target. Updates on the falling edge.
// Ports:
//   clock          in   pipeline clock (falling-edge active)
//   reset          in   synchronous active-high reset, PC <= RESET_PC
//   advance        in   step PC to the next sequential instruction
//   redirect       in   load PC from redirectTarget (wins over advance)
//   redirectTarget in   branch target, low two bits ignored
//   pc             out  current fetch PC
//   pcPlus4        out  pc + PC_INCREMENT, 32-bit modulo
// ---------------------------------------------------------------------------
module pc_register
  import if_id_fetch_stage_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        advance,
  input  logic        redirect,
  input  logic [31:0] redirectTarget,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4
);

  // Redirect beats advance so a taken branch always wins over the
  // sequential path; the addition simply wraps at the top of memory.
  always_ff @(negedge clock) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= wordAlign(redirectTarget);
    end else if (advance) begin
      pc <= pc + PC_INCREMENT;
    end
  end

  assign pcPlus4 = pc + PC_INCREMENT;

endmodule

// File: rtl/if_id_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_id_fetch_stage
// Instruction fetch stage with its IF/ID pipeline register. Issues word
// fetches to instruction memory, tolerates memory wait states and decode
// stalls with a one-entry buffer, and handles branch redirects including
// draining a fetch that is still outstanding when the branch arrives.
// All state updates happen on the falling edge of clock.
// Ports:
//   clock          in   pipeline clock (falling-edge active)
//   reset          in   synchronous active-high reset
//   hit            in   pipeline advance enable, 0 = stall
//   branchTaken    in   redirect request from branch resolution
//   branchTarget   in   redirect PC, low two bits ignored
//   imemRequest    out  instruction memory read request
//   imemAddress    out  word-aligned fetch address
//   imemReady      in   memory completion, imemData valid this cycle
//   imemData       in   fetched instruction word
//   instructionOut out  IF/ID instruction
//   nextPCOut      out  fetch address + 4 of instructionOut
//   validOut       out  instructionOut is a real instruction
// ---------------------------------------------------------------------------
module if_id_fetch_stage
  import if_id_fetch_stage_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        hit,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  output logic        imemRequest,
  output logic [31:0] imemAddress,
  input  logic        imemReady,
  input  logic [31:0] imemData,
  output logic [31:0] instructionOut,
  output logic [31:0] nextPCOut,
  output logic        validOut
);

  fetchState_t state;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic [31:0] drainAddress;
  logic [31:0] bufferWord;
  logic        bufferValid;
  logic        transferDone;
  logic        pcAdvance;
  logic        pcRedirect;

  pc_register pcReg (
    .clock          (clock),
    .reset          (reset),
    .advance        (pcAdvance),
    .redirect       (pcRedirect),
    .redirectTarget (branchTarget),
    .pc             (pc),
    .pcPlus4        (pcPlus4)
  );

  // Memory is idle only while a word sits in the stall buffer. During DRAIN
  // the PC already points at the branch target, so the abandoned request
  // keeps presenting its original address until memory finishes it.
  assign imemRequest  = (state != HOLD);
  assign imemAddress  = (state == DRAIN) ? drainAddress : pc;
  assign transferDone = imemRequest & imemReady;

  // The PC moves on only when an instruction actually enters IF/ID: either
  // straight from memory or out of the stall buffer.
  always_comb begin
    pcRedirect = branchTaken;
    pcAdvance  = 1'b0;
    if (!branchTaken && hit) begin
      case (state)
        FETCH:   pcAdvance = imemReady;
        HOLD:    pcAdvance = bufferValid;
        default: pcAdvance = 1'b0;
      endcase
    end
  end

  // Fetch FSM, stall buffer and IF/ID register. A bubble clears the
  // instruction and valid flag but leaves nextPCOut as it was, since decode
  // ignores it when validOut is low.
  always_ff @(negedge clock) begin
    if (reset) begin
      state          <= FETCH;
      bufferValid    <= 1'b0;
      bufferWord     <= NOP_WORD;
      drainAddress   <= RESET_PC;
      instructionOut <= NOP_WORD;
      nextPCOut      <= RESET_PC;
      validOut       <= 1'b0;
    end else if (branchTaken) begin
      instructionOut <= NOP_WORD;
      validOut       <= 1'b0;
      bufferValid    <= 1'b0;
      case (state)
        FETCH: begin
          if (!transferDone) begin
            state        <= DRAIN;
            drainAddress <= pc;
          end
        end
        HOLD:    state <= FETCH;
        DRAIN:   if (transferDone) state <= FETCH;
        default: state <= FETCH;
      endcase
    end else begin
      case (state)
        FETCH: begin
          if (transferDone) begin
            if (hit) begin
              instructionOut <= imemData;
              nextPCOut      <= pcPlus4;
              validOut       <= 1'b1;
            end else begin
              bufferWord  <= imemData;
              bufferValid <= 1'b1;
              state       <= HOLD;
            end
          end else if (hit) begin
            instructionOut <= NOP_WORD;
            validOut       <= 1'b0;
          end
        end
        HOLD: begin
          if (hit) begin
            instructionOut <= bufferWord;
            nextPCOut      <= pcPlus4;
            validOut       <= bufferValid;
            bufferValid    <= 1'b0;
            state          <= FETCH;
          end
        end
        DRAIN: begin
          if (transferDone) begin
            state <= FETCH;
          end
          if (hit) begin
            instructionOut <= NOP_WORD;
            validOut       <= 1'b0;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_id_fetch_stage
// Self-checking bench for if_id_fetch_stage: a directed table of multi-cycle
// sequences with hand-computed expectations, then randomized traffic checked
// against a behavioural model of the fetch stage.
// ---------------------------------------------------------------------------
module tb_if_id_fetch_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        hit;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic        imemRequest;
  logic [31:0] imemAddress;
  logic        imemReady;
  logic [31:0] imemData;
  logic [31:0] instructionOut;
  logic [31:0] nextPCOut;
  logic        validOut;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        rst;
    logic        hit;
    logic        br;
    logic [31:0] tgt;
    logic        rdy;
    logic [31:0] data;
    logic        chkPre;
    logic        expReq;
    logic [31:0] expAddr;
    logic        expValid;
    logic [31:0] expInstr;
    logic [31:0] expNext;
  } vector_t;

  vector_t vectors[$];

  // Behavioural model state: what the stage holds, in plain terms.
  logic [31:0] mPc;
  logic        mHeld;
  logic [31:0] mHeldWord;
  logic        mDraining;
  logic [31:0] mDrainAddr;
  logic [31:0] mInstr;
  logic [31:0] mNext;
  logic        mValid;

  if_id_fetch_stage dut (
    .clock          (clock),
    .reset          (reset),
    .hit            (hit),
    .branchTaken    (branchTaken),
    .branchTarget   (branchTarget),
    .imemRequest    (imemRequest),
    .imemAddress    (imemAddress),
    .imemReady      (imemReady),
    .imemData       (imemData),
    .instructionOut (instructionOut),
    .nextPCOut      (nextPCOut),
    .validOut       (validOut)
  );

  always #5 clock = ~clock;

  function automatic vector_t row(
    input logic rst, input logic h, input logic br, input logic [31:0] tgt,
    input logic rdy, input logic [31:0] data, input logic chkPre,
    input logic expReq, input logic [31:0] expAddr, input logic expValid,
    input logic [31:0] expInstr, input logic [31:0] expNext);
    vector_t v;
    v.rst = rst; v.hit = h; v.br = br; v.tgt = tgt; v.rdy = rdy;
    v.data = data; v.chkPre = chkPre; v.expReq = expReq;
    v.expAddr = expAddr; v.expValid = expValid; v.expInstr = expInstr;
    v.expNext = expNext;
    return v;
  endfunction

  task automatic checkValue(input string name, input int idx,
                            input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s step %0d: got %h, expected %h", name, idx, actual, expected);
    end
  endtask

  // Drive inputs just after the rising edge, so they are stable well before
  // the falling edge that samples them, then check the memory-side outputs.
  task automatic applyStimulus(input int idx, input logic rst, input logic h,
                               input logic br, input logic [31:0] tgt,
                               input logic rdy, input logic [31:0] data,
                               input logic chkPre, input logic expReq,
                               input logic [31:0] expAddr);
    reset        = rst;
    hit          = h;
    branchTaken  = br;
    branchTarget = tgt;
    imemReady    = rdy;
    imemData     = data;
    #1;
    if (chkPre) begin
      checkValue("imemRequest", idx, {31'b0, imemRequest}, {31'b0, expReq});
      if (expReq) checkValue("imemAddress", idx, imemAddress, expAddr);
    end
  endtask

  // Let the falling edge update the stage, then check the IF/ID register
  // on the following rising edge.
  task automatic checkOutput(input int idx, input logic rst, input logic expValid,
                             input logic [31:0] expInstr, input logic [31:0] expNext);
    @(negedge clock);
    @(posedge clock);
    #1;
    checkValue("validOut", idx, {31'b0, validOut}, {31'b0, expValid});
    checkValue("instructionOut", idx, instructionOut, expInstr);
    if (expValid || rst) checkValue("nextPCOut", idx, nextPCOut, expNext);
  endtask

  // Reference behaviour for one clock, written from the stage's rules:
  // memory is asked for a word unless one is parked; a branch always empties
  // IF/ID and the parked word, and an unfinished fetch must still be drained.
  task automatic modelStep(input logic rst, input logic h, input logic br,
                           input logic [31:0] tgt, input logic rdy,
                           input logic [31:0] data);
    logic done;
    done = !mHeld && rdy;
    if (rst) begin
      mPc = 0; mHeld = 0; mDraining = 0; mInstr = 0; mNext = 0; mValid = 0;
    end else if (br) begin
      if (mDraining) mDraining = !done;
      else if (!mHeld && !done) begin
        mDraining  = 1;
        mDrainAddr = mPc;
      end
      mHeld  = 0;
      mPc    = tgt & 32'hFFFF_FFFC;
      mInstr = 0;
      mValid = 0;
    end else if (mDraining) begin
      if (done) mDraining = 0;
      if (h) begin mInstr = 0; mValid = 0; end
    end else if (mHeld) begin
      if (h) begin
        mInstr = mHeldWord; mNext = mPc + 4; mValid = 1;
        mPc    = mPc + 4;   mHeld = 0;
      end
    end else if (done) begin
      if (h) begin
        mInstr = data; mNext = mPc + 4; mValid = 1; mPc = mPc + 4;
      end else begin
        mHeld = 1; mHeldWord = data;
      end
    end else if (h) begin
      mInstr = 0; mValid = 0;
    end
  endtask

  initial begin
    // Directed sequences: zero-wait streaming, decode stall with buffered
    // word, two-cycle latency, branch during outstanding fetch, PC wrap,
    // and reset together with a branch mid-transfer.
    vectors.push_back(row(1,1,1,32'h44,0,0,                0,0,0,           0,0,0));
    vectors.push_back(row(0,1,0,0,1,32'h2008_0005,         1,1,0,           1,32'h2008_0005,4));
    vectors.push_back(row(0,1,0,0,1,32'h1111_1111,         1,1,4,           1,32'h1111_1111,8));
    vectors.push_back(row(0,1,0,0,1,32'h2222_2222,         1,1,8,           1,32'h2222_2222,32'hC));
    vectors.push_back(row(0,1,0,0,1,32'h3333_3333,         1,1,32'hC,       1,32'h3333_3333,32'h10));
    vectors.push_back(row(0,0,0,0,1,32'hAAAA_0010,         1,1,32'h10,      1,32'h3333_3333,32'h10));
    vectors.push_back(row(0,0,0,0,1,32'h5555_5555,         1,0,0,           1,32'h3333_3333,32'h10));
    vectors.push_back(row(0,0,0,0,0,0,                     1,0,0,           1,32'h3333_3333,32'h10));
    vectors.push_back(row(0,1,0,0,0,0,                     1,0,0,           1,32'hAAAA_0010,32'h14));
    vectors.push_back(row(0,1,0,0,0,0,                     1,1,32'h14,      0,0,0));
    vectors.push_back(row(0,1,0,0,1,32'hBBBB_0014,         1,1,32'h14,      1,32'hBBBB_0014,32'h18));
    vectors.push_back(row(1,1,0,0,1,32'hFFFF,              1,1,32'h18,      0,0,0));
    vectors.push_back(row(0,1,0,0,1,32'h1,                 1,1,0,           1,32'h1,4));
    vectors.push_back(row(0,1,0,0,1,32'h2,                 1,1,4,           1,32'h2,8));
    vectors.push_back(row(0,1,1,32'h43,0,0,                1,1,8,           0,0,0));
    vectors.push_back(row(0,1,0,0,0,0,                     1,1,8,           0,0,0));
    vectors.push_back(row(0,1,0,0,1,32'hDEAD_0008,         1,1,8,           0,0,0));
    vectors.push_back(row(0,1,0,0,0,0,                     1,1,32'h40,      0,0,0));
    vectors.push_back(row(0,1,0,0,1,32'h4040_4040,         1,1,32'h40,      1,32'h4040_4040,32'h44));
    vectors.push_back(row(0,1,1,32'hFFFF_FFFF,1,32'h7777_7777, 1,1,32'h44,  0,0,0));
    vectors.push_back(row(0,1,0,0,1,32'hCAFE_F00D,         1,1,32'hFFFF_FFFC, 1,32'hCAFE_F00D,0));
    vectors.push_back(row(0,1,0,0,0,0,                     1,1,0,           0,0,0));
    vectors.push_back(row(0,1,1,32'h80,0,0,                1,1,0,           0,0,0));
    vectors.push_back(row(1,1,1,32'h100,0,0,               1,1,0,           0,0,0));
    vectors.push_back(row(0,1,0,0,0,0,                     1,1,0,           0,0,0));

    reset = 1; hit = 0; branchTaken = 0; branchTarget = 0;
    imemReady = 0; imemData = 0;
    @(posedge clock);
    #1;

    for (int i = 0; i < vectors.size(); i++) begin
      applyStimulus(i, vectors[i].rst, vectors[i].hit, vectors[i].br,
                    vectors[i].tgt, vectors[i].rdy, vectors[i].data,
                    vectors[i].chkPre, vectors[i].expReq, vectors[i].expAddr);
      checkOutput(i, vectors[i].rst, vectors[i].expValid,
                  vectors[i].expInstr, vectors[i].expNext);
    end

    // Randomized traffic against the model; the first cycle resets both.
    mPc = 0; mHeld = 0; mHeldWord = 0; mDraining = 0; mDrainAddr = 0;
    mInstr = 0; mNext = 0; mValid = 0;
    for (int n = 0; n < 600; n++) begin
      logic        rRst, rHit, rBr, rRdy;
      logic [31:0] rTgt, rData;
      logic        expReq;
      logic [31:0] expAddr;
      rRst  = (n == 0) || ($urandom_range(0, 59) == 0);
      rHit  = ($urandom_range(0, 3) != 0);
      rBr   = ($urandom_range(0, 7) == 0);
      rRdy  = ($urandom_range(0, 1) == 1);
      rTgt  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      rData = $urandom;
      expReq  = !mHeld;
      expAddr = mDraining ? mDrainAddr : mPc;
      applyStimulus(1000 + n, rRst, rHit, rBr, rTgt, rRdy, rData,
                    (n != 0), expReq, expAddr);
      modelStep(rRst, rHit, rBr, rTgt, rRdy, rData);
      checkOutput(1000 + n, rRst, mValid, mInstr, mNext);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
